// File: rtl/dot_seq_pkg.sv
// Shared types for the dot_product sequencer: reduction codes and FSM states.
package dot_seq_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'b00,
        SHIFT = 2'b01,
        ACC   = 2'b10,
        CLEAR = 2'b11
    } dot_ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DRAIN = 2'b10,
        FIN   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/dot_ctrl_delay.sv
// Fixed-latency pipe for reduction codes; the last stage drives dot_ctrl directly.
module dot_ctrl_delay
    import dot_seq_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  dot_ctrl_e i_code,
    output dot_ctrl_e o_code,
    output logic      o_empty
);

    dot_ctrl_e r_pipe [LAT];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) r_pipe[i] <= NOP;
        end else begin
            r_pipe[0] <= i_code;
            for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Empty means nothing is still upstream of the output stage.
    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (r_pipe[i] != NOP) o_empty = 1'b0;
        end
    end

    assign o_code = r_pipe[LAT-1];

endmodule

// File: rtl/dot_seq_ctrl.sv
// Job sequencer for dot_product: issues operand beats and times the reduction codes.
//   state | meaning
//   IDLE  | waiting for start, config sampled here
//   ISSUE | one beat offered per cycle until the final beat fires
//   DRAIN | waiting for the last code to reach dot_ctrl
//   FIN   | one-cycle done (and err for a rejected config)
module dot_seq_ctrl
    import dot_seq_pkg::*;
#(
    parameter int PE_COUNT   = 4,
    parameter int MAX_CHUNKS = 16,
    parameter int PE_LAT     = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [$clog2(PE_COUNT+1)-1:0]   cfg_rows,
    input  logic [$clog2(MAX_CHUNKS+1)-1:0] cfg_chunks,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [$clog2(PE_COUNT)-1:0]     issue_row,
    output logic [$clog2(MAX_CHUNKS)-1:0]   issue_chunk,
    output logic [1:0]                      dot_ctrl
);

    localparam int RW  = $clog2(PE_COUNT + 1);
    localparam int IRW = $clog2(PE_COUNT);
    localparam int CCW = $clog2(MAX_CHUNKS + 1);
    localparam int ICW = $clog2(MAX_CHUNKS);

    seq_state_e     r_state;
    seq_state_e     w_state_nxt;
    logic [RW-1:0]  r_rows;
    logic [CCW-1:0] r_chunks;
    logic [IRW-1:0] r_row;
    logic [ICW-1:0] r_chunk;
    logic           r_err;

    logic           w_cfg_ok;
    logic           w_fire;
    logic           w_last_chunk;
    logic           w_last_row;
    logic           w_empty;
    dot_ctrl_e      w_code;
    dot_ctrl_e      w_dot;

    assign w_cfg_ok     = (cfg_rows != '0) && (cfg_rows <= RW'(PE_COUNT)) &&
                          (cfg_chunks != '0) && (cfg_chunks <= CCW'(MAX_CHUNKS));
    assign w_fire       = issue_valid & issue_ready;
    assign w_last_chunk = (CCW'(r_chunk) == r_chunks - CCW'(1));
    assign w_last_row   = (RW'(r_row) == r_rows - RW'(1));

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        issue_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = w_cfg_ok ? ISSUE : FIN;
            end
            ISSUE: begin
                busy        = 1'b1;
                issue_valid = 1'b1;
                if (issue_ready && w_last_chunk && w_last_row) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_empty) w_state_nxt = FIN;
            end
            FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                err         = r_err;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counters return to 0 after the final beat so row never reaches PE_COUNT.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rows   <= '0;
            r_chunks <= '0;
            r_row    <= '0;
            r_chunk  <= '0;
            r_err    <= 1'b0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_err <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_rows   <= cfg_rows;
                    r_chunks <= cfg_chunks;
                    r_row    <= '0;
                    r_chunk  <= '0;
                end
            end
        end else if (w_fire) begin
            if (w_last_chunk) begin
                r_chunk <= '0;
                r_row   <= w_last_row ? '0 : r_row + IRW'(1);
            end else begin
                r_chunk <= r_chunk + ICW'(1);
            end
        end
    end

    always_comb begin
        w_code = NOP;
        if (w_fire) begin
            if (r_chunk != '0)    w_code = ACC;
            else if (r_row == '0) w_code = CLEAR;
            else                  w_code = SHIFT;
        end
    end

    dot_ctrl_delay #(
        .LAT(PE_LAT)
    ) u_delay (
        .clk    (clk),
        .rstn   (rstn),
        .i_code (w_code),
        .o_code (w_dot),
        .o_empty(w_empty)
    );

    assign issue_row   = r_row;
    assign issue_chunk = r_chunk;
    assign dot_ctrl    = w_dot;

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// Bench for dot_seq_ctrl: directed jobs plus random jobs against a beat-list reference model.
module tb_dot_seq_ctrl;
    import dot_seq_pkg::*;

    localparam int PE_COUNT   = 4;
    localparam int MAX_CHUNKS = 16;
    localparam int PE_LAT     = 2;
    localparam int RW  = $clog2(PE_COUNT + 1);
    localparam int IRW = $clog2(PE_COUNT);
    localparam int CCW = $clog2(MAX_CHUNKS + 1);
    localparam int ICW = $clog2(MAX_CHUNKS);
    localparam int MAX_CYC = 1000;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic [RW-1:0]  cfg_rows;
    logic [CCW-1:0] cfg_chunks;
    logic           busy, done, err, issue_valid, issue_ready;
    logic [IRW-1:0] issue_row;
    logic [ICW-1:0] issue_chunk;
    logic [1:0]     dot_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dot_seq_ctrl #(
        .PE_COUNT  (PE_COUNT),
        .MAX_CHUNKS(MAX_CHUNKS),
        .PE_LAT    (PE_LAT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .cfg_rows   (cfg_rows),
        .cfg_chunks (cfg_chunks),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_row  (issue_row),
        .issue_chunk(issue_chunk),
        .dot_ctrl   (dot_ctrl)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // One job starting at cycle 0. ready_mode: 0 always, 1 low in cycles 2-3, 2 random.
    // rst_at >= 0 pulls rstn low in that cycle; the job is then expected to vanish.
    task automatic run_job(input int rows, input int chunks, input int ready_mode,
                           input bit repulse, input int rst_at);
        int  exp_ctrl [MAX_CYC + 8];
        bit  legal;
        int  total, k, done_c;
        bit  ended;
        bit  exp_valid;
        int  code;
        legal  = rows >= 1 && rows <= PE_COUNT && chunks >= 1 && chunks <= MAX_CHUNKS;
        total  = rows * chunks;
        k      = 0;
        done_c = legal ? -1 : 1;
        ended  = 1'b0;
        for (int i = 0; i < MAX_CYC + 8; i++) exp_ctrl[i] = int'(NOP);
        for (int c = 0; c < MAX_CYC; c++) begin
            @(posedge clk);
            #1;
            start       = (c == 0) || (repulse && c == 4);
            cfg_rows    = (c == 0) ? RW'(rows)   : RW'($urandom);
            cfg_chunks  = (c == 0) ? CCW'(chunks) : CCW'($urandom);
            rstn        = (c != rst_at);
            case (ready_mode)
                0:       issue_ready = 1'b1;
                1:       issue_ready = !(c == 2 || c == 3);
                default: issue_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (rst_at >= 0 && c == rst_at + 1) begin
                check_eq("rst_valid", int'(issue_valid), 0);
                check_eq("rst_busy",  int'(busy), 0);
                check_eq("rst_done",  int'(done), 0);
                check_eq("rst_err",   int'(err), 0);
                check_eq("rst_dot",   int'(dot_ctrl), int'(NOP));
                check_eq("rst_row",   int'(issue_row), 0);
                check_eq("rst_chunk", int'(issue_chunk), 0);
                ended = 1'b1;
                break;
            end
            exp_valid = legal && c >= 1 && k < total;
            check_eq("valid", int'(issue_valid), int'(exp_valid));
            check_eq("busy",  int'(busy), int'(c >= 1 && (done_c < 0 || c <= done_c)));
            check_eq("done",  int'(done), int'(c == done_c));
            check_eq("err",   int'(err),  int'(c == done_c && !legal));
            check_eq("dot",   int'(dot_ctrl), exp_ctrl[c]);
            if (exp_valid) begin
                check_eq("row",   int'(issue_row),   k / chunks);
                check_eq("chunk", int'(issue_chunk), k % chunks);
                if (issue_ready) begin
                    if (k == 0)               code = int'(CLEAR);
                    else if (k % chunks == 0) code = int'(SHIFT);
                    else                      code = int'(ACC);
                    exp_ctrl[c + PE_LAT] = code;
                    if (k == total - 1) done_c = c + PE_LAT + 1;
                    k++;
                end
            end
            if (c == done_c) begin
                ended = 1'b1;
                break;
            end
        end
        check_eq("job_end", int'(ended), 1);
    endtask

    initial begin
        int r, ch, rs;
        rstn        = 1'b0;
        start       = 1'b0;
        cfg_rows    = '0;
        cfg_chunks  = '0;
        issue_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("init_valid", int'(issue_valid), 0);
        check_eq("init_busy",  int'(busy), 0);
        check_eq("init_done",  int'(done), 0);
        check_eq("init_err",   int'(err), 0);
        check_eq("init_dot",   int'(dot_ctrl), 0);
        check_eq("init_row",   int'(issue_row), 0);
        check_eq("init_chunk", int'(issue_chunk), 0);
        rstn = 1'b1;

        run_job(2, 3, 0, 1'b0, -1);
        run_job(2, 3, 1, 1'b0, -1);
        run_job(1, 1, 0, 1'b0, -1);
        run_job(5, 3, 0, 1'b0, -1);
        run_job(2, 0, 0, 1'b0, -1);
        run_job(2, 3, 0, 1'b1, -1);
        run_job(2, 3, 0, 1'b0, 5);
        run_job(2, 3, 0, 1'b0, -1);
        run_job(PE_COUNT, MAX_CHUNKS, 2, 1'b0, -1);
        run_job(PE_COUNT, 1, 0, 1'b0, -1);

        for (int j = 0; j < 30; j++) begin
            r  = $urandom_range(0, 6);
            ch = $urandom_range(0, 18);
            rs = -1;
            if (r >= 1 && r <= PE_COUNT && ch >= 1 && ch <= MAX_CHUNKS &&
                $urandom_range(0, 7) == 0)
                rs = $urandom_range(1, 3);
            run_job(r, ch, 2, 1'($urandom_range(0, 1)), rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
